// File: rtl/transpose_pingpong_buffer.sv
// Streaming N x N matrix transposer with two ping-pong banks: rows in, columns out (optional macro TRANSPOSE_BYPASS_EN).
// Latency: first column is valid the cycle after the last row of a matrix is accepted.
// Backpressure: in_ready drops only when both banks hold unread data; out_ready low freezes the output column.
module transpose_pingpong_buffer #(
  parameter int DATA_WIDTH     = 16,
  parameter int SYSTOLIC_WIDTH = 4
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 clear,
`ifdef TRANSPOSE_BYPASS_EN
  input  logic                                 cfg_bypass,
`endif
  input  logic [SYSTOLIC_WIDTH*DATA_WIDTH-1:0] in_data,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  output logic [SYSTOLIC_WIDTH*DATA_WIDTH-1:0] out_data,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic                                 out_last,
  output logic                                 busy
);

  localparam int N  = SYSTOLIC_WIDTH;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    FILLING  = 2'd1,
    FULL     = 2'd2,
    DRAINING = 2'd3
  } bank_state_t;

  bank_state_t           bank_q [2];
  bank_state_t           bank_d [2];
  logic                  wr_bank;
  logic                  rd_bank;
  logic [CW-1:0]         row_cnt;
  logic [CW-1:0]         col_cnt;
  logic [DATA_WIDTH-1:0] mem [2][N][N];
  logic                  wr_fire;
  logic                  rd_fire;
  logic                  rd_bypass;

  // Handshake qualifiers depend only on registered bank state.
  assign in_ready  = (bank_q[wr_bank] == EMPTY) || (bank_q[wr_bank] == FILLING);
  assign out_valid = (bank_q[rd_bank] == FULL)  || (bank_q[rd_bank] == DRAINING);
  assign wr_fire   = in_valid  & in_ready;
  assign rd_fire   = out_valid & out_ready;
  assign out_last  = out_valid & (col_cnt == LAST_IDX);
  assign busy      = (bank_q[0] != EMPTY) || (bank_q[1] != EMPTY);

  // Bank state next-value: writer and reader never touch the same bank in the same state.
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      bank_d[b] = bank_q[b];
      if (wr_fire && (wr_bank == 1'(b)))
        bank_d[b] = (row_cnt == LAST_IDX) ? FULL : FILLING;
      if (rd_fire && (rd_bank == 1'(b)))
        bank_d[b] = (col_cnt == LAST_IDX) ? EMPTY : DRAINING;
    end
  end

  // Bank state register; clear outranks any transfer in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_q[0] <= EMPTY;
      bank_q[1] <= EMPTY;
    end else if (clear) begin
      bank_q[0] <= EMPTY;
      bank_q[1] <= EMPTY;
    end else begin
      bank_q[0] <= bank_d[0];
      bank_q[1] <= bank_d[1];
    end
  end

  // Row/column counters and bank pointers wrap and toggle at the end of each matrix.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      row_cnt <= '0;
      col_cnt <= '0;
    end else if (clear) begin
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      row_cnt <= '0;
      col_cnt <= '0;
    end else begin
      if (wr_fire) begin
        if (row_cnt == LAST_IDX) begin
          row_cnt <= '0;
          wr_bank <= ~wr_bank;
        end else begin
          row_cnt <= row_cnt + 1'b1;
        end
      end
      if (rd_fire) begin
        if (col_cnt == LAST_IDX) begin
          col_cnt <= '0;
          rd_bank <= ~rd_bank;
        end else begin
          col_cnt <= col_cnt + 1'b1;
        end
      end
    end
  end

  // Element storage; contents are left as-is on reset since bank state gates all reads.
  always_ff @(posedge clk) begin
    if (wr_fire && !clear) begin
      for (int k = 0; k < N; k++)
        mem[wr_bank][row_cnt][k] <= in_data[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

`ifdef TRANSPOSE_BYPASS_EN
  logic [1:0] bypass_q;

  // Mode is latched once per bank as it leaves EMPTY, so mid-matrix changes are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bypass_q <= 2'b00;
    end else if (wr_fire && !clear && (bank_q[wr_bank] == EMPTY)) begin
      bypass_q[wr_bank] <= cfg_bypass;
    end
  end

  assign rd_bypass = bypass_q[rd_bank];
`else
  assign rd_bypass = 1'b0;
`endif

  // Output column mux: lane r is M[r][col] (transpose) or M[col][r] (bypass); zero when idle.
  always_comb begin
    out_data = '0;
    if (out_valid) begin
      for (int r = 0; r < N; r++) begin
        if (rd_bypass)
          out_data[r*DATA_WIDTH +: DATA_WIDTH] = mem[rd_bank][col_cnt][r];
        else
          out_data[r*DATA_WIDTH +: DATA_WIDTH] = mem[rd_bank][r][col_cnt];
      end
    end
  end

endmodule

// File: tb/tb_transpose_pingpong_buffer.sv
// Self-checking bench for transpose_pingpong_buffer: scoreboard of expected columns built from accepted rows.
// Stimulus drives rows and out_ready; a monitor pops and compares on every output transfer.
// Bypass scenario is built only when TRANSPOSE_BYPASS_EN is defined.
module tb_transpose_pingpong_buffer;
  localparam int N  = 4;
  localparam int W  = 16;
  localparam int DW = N * W;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clear;
  logic          cfg_bypass;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic          busy;

  transpose_pingpong_buffer #(.DATA_WIDTH(W), .SYSTOLIC_WIDTH(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
`ifdef TRANSPOSE_BYPASS_EN
    .cfg_bypass(cfg_bypass),
`endif
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors     = 0;
  int miscompares = 0;
  int stall_cnt   = 0;

  logic [DW:0]   exp_q[$];      // {last, column}
  logic [DW-1:0] cur_rows[$];   // rows of the matrix currently being loaded
  logic          cur_bypass;
  int unsigned   xfer_cyc_q[$];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: once N rows are in, emit the N output beats of that matrix.
  function automatic void model_row(input logic [DW-1:0] row);
    logic [DW-1:0] col;
    if (cur_rows.size() == 0) cur_bypass = cfg_bypass;
    cur_rows.push_back(row);
    if (cur_rows.size() == N) begin
      for (int c = 0; c < N; c++) begin
        col = '0;
        for (int r = 0; r < N; r++) begin
          if (cur_bypass) col[r*W +: W] = cur_rows[c][r*W +: W];
          else            col[r*W +: W] = cur_rows[r][c*W +: W];
        end
        exp_q.push_back({(c == N - 1), col});
      end
      cur_rows.delete();
    end
  endfunction

  function automatic void model_flush();
    cur_rows.delete();
    exp_q.delete();
  endfunction

  task automatic send_row(input logic [DW-1:0] d);
    int   waited;
    logic ok;
    in_valid = 1'b1;
    in_data  = d;
    waited   = 0;
    do begin
      @(negedge clk);
      ok = in_ready;
      if (!ok) stall_cnt++;
      @(posedge clk);
      #1;
      waited++;
    end while (!ok && waited < 500);
    if (!ok) begin
      vectors++;
      miscompares++;
      $display("FAIL send_timeout: in_ready got 0 expected 1");
    end else begin
      model_row(d);
    end
  endtask

  task automatic send_matrix();
    for (int r = 0; r < N; r++) send_row({$urandom, $urandom});
  endtask

  task automatic wait_drain();
    int i;
    i = 0;
    while ((exp_q.size() != 0 || busy) && i < 400) begin
      @(posedge clk);
      #1;
      i++;
    end
    check("drain_done", {62'd0, (exp_q.size() != 0), busy}, '0);
  endtask

  // Monitor: output stability under stall and scoreboard comparison on each transfer.
  initial begin
    logic          prev_stall;
    logic [DW-1:0] prev_data;
    logic [DW:0]   e;
    prev_stall = 1'b0;
    prev_data  = '0;
    forever begin
      @(negedge clk);
      if (!rst_n || clear) begin
        prev_stall = 1'b0;
        continue;
      end
      if (prev_stall) begin
        check("hold_valid", DW'(out_valid), DW'(1));
        check("hold_data", out_data, prev_data);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_col: got %h expected no column", out_data);
        end else begin
          e = exp_q.pop_front();
          check("col_data", out_data, e[DW-1:0]);
          check("col_last", DW'(out_last), DW'(e[DW]));
          xfer_cyc_q.push_back(cyc);
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time got limit expected earlier finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    logic done;
    rst_n = 1'b0; clear = 1'b0; cfg_bypass = 1'b0;
    in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", DW'(in_ready), DW'(1));
    check("rst_out_valid", DW'(out_valid), '0);
    check("rst_out_last", DW'(out_last), '0);
    check("rst_busy", DW'(busy), '0);
    check("rst_out_data", out_data, '0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed matrix: element M[r][k] = 0x00rk.
    out_ready = 1'b1;
    for (int r = 0; r < N; r++) begin
      logic [DW-1:0] row;
      for (int k = 0; k < N; k++) row[k*W +: W] = W'(r * 16 + k);
      send_row(row);
      if (r == N - 2) check("lat_not_yet", DW'(out_valid), '0);
    end
    in_valid = 1'b0;
    check("lat_valid", DW'(out_valid), DW'(1));
    check("beat0", out_data, 64'h0030_0020_0010_0000);
    repeat (3) @(posedge clk);
    #1;
    check("beat3", out_data, 64'h0033_0023_0013_0003);
    check("beat3_last", DW'(out_last), DW'(1));
    wait_drain();

    // Back-to-back 3 matrices with no stalls on either side.
    xfer_cyc_q.delete();
    s0 = stall_cnt;
    for (int m = 0; m < 3; m++) send_matrix();
    in_valid = 1'b0;
    wait_drain();
    check("b2b_no_stall", DW'(stall_cnt - s0), '0);
    check("b2b_cols", DW'(xfer_cyc_q.size()), DW'(12));
    if (xfer_cyc_q.size() > 0)
      check("b2b_span", DW'(xfer_cyc_q[xfer_cyc_q.size()-1] - xfer_cyc_q[0]), DW'(11));

    // Fill both banks with the reader stalled, then release.
    out_ready = 1'b0;
    send_matrix();
    send_matrix();
    in_valid = 1'b0;
    check("full_in_ready", DW'(in_ready), '0);
    check("full_busy", DW'(busy), DW'(1));
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("free_not_yet", DW'(in_ready), '0);
    @(posedge clk);
    #1;
    check("free_in_ready", DW'(in_ready), DW'(1));
    wait_drain();

    // Random reader backpressure across 5 matrices.
    done = 1'b0;
    fork
      begin
        for (int m = 0; m < 5; m++) send_matrix();
        in_valid = 1'b0;
        done = 1'b1;
      end
      begin
        while (!done) begin
          out_ready = 1'($urandom_range(0, 1));
          @(posedge clk);
          #1;
        end
      end
    join
    out_ready = 1'b1;
    wait_drain();

    // Reset in the middle of a matrix discards it.
    send_row({$urandom, $urandom});
    send_row({$urandom, $urandom});
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    model_flush();
    check("mid_rst_in_ready", DW'(in_ready), DW'(1));
    check("mid_rst_out_valid", DW'(out_valid), '0);
    check("mid_rst_busy", DW'(busy), '0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    send_matrix();
    in_valid = 1'b0;
    wait_drain();

    // Synchronous clear in the middle of a matrix.
    send_row({$urandom, $urandom});
    send_row({$urandom, $urandom});
    in_valid = 1'b0;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    model_flush();
    check("clr_busy", DW'(busy), '0);
    check("clr_in_ready", DW'(in_ready), DW'(1));
    check("clr_out_valid", DW'(out_valid), '0);
    send_matrix();
    in_valid = 1'b0;
    wait_drain();

`ifdef TRANSPOSE_BYPASS_EN
    // Bypass matrix A, transposed matrix B with cfg_bypass flipped after its first row.
    cfg_bypass = 1'b1;
    send_matrix();
    in_valid = 1'b0;
    wait_drain();
    cfg_bypass = 1'b0;
    send_row({$urandom, $urandom});
    cfg_bypass = 1'b1;
    for (int r = 1; r < N; r++) send_row({$urandom, $urandom});
    in_valid = 1'b0;
    wait_drain();
    cfg_bypass = 1'b0;
    send_row({$urandom, $urandom});
    send_row({$urandom, $urandom});
    in_valid = 1'b0;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    model_flush();
    check("byp_clr_busy", DW'(busy), '0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/transpose_pingpong_buffer.md
Name: transpose_pingpong_buffer

Overview:
- Streaming N x N matrix transposer for the systolic array datapath; next generation of the single-bank transposition register array.
- Fully parametrised width and depth.
- Two ping-pong banks so loading of matrix k+1 overlaps draining of matrix k.
- valid/ready handshakes on both sides.
- Sits between the operand fetch stage (row-major rows in) and the systolic array edge (columns out).

Parameters:
- DATA_WIDTH, 16, bits per matrix element.
- SYSTOLIC_WIDTH, 4, matrix dimension N: elements per beat and beats per matrix. Legal values are 2 and above.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- clear  input  1  synchronous flush: empties both banks and resets all counters.
- in_data  input  SYSTOLIC_WIDTH*DATA_WIDTH  one matrix row; element k at [(k+1)*DATA_WIDTH-1 : k*DATA_WIDTH].
- in_valid  input  1  in_data valid.
- in_ready  output  1  buffer can accept a row.
- out_data  output  SYSTOLIC_WIDTH*DATA_WIDTH  one matrix column; same lane packing as in_data.
- out_valid  output  1  out_data valid.
- out_ready  input  1  consumer accepts out_data.
- out_last  output  1  asserted with the final column (index N-1) of a matrix.
- busy  output  1  at least one bank is non-empty.

Behaviour:
- Reset and clear:
  - Asynchronous reset (rst_n low) or clear high at a clock edge: both banks EMPTY, wr_bank=0, rd_bank=0, row_cnt=0, col_cnt=0.
  - Outputs after reset: in_ready=1, out_valid=0, out_last=0, busy=0, out_data=0.
  - Bank storage contents need not be cleared.
  - clear has priority over any simultaneous transfer.
  - Reset or clear mid-matrix discards the partial matrix.
- Bank states: each bank is EMPTY, FILLING, FULL or DRAINING.
  - EMPTY -> FILLING on the first accepted row.
  - FILLING -> FULL on the accepted row with row_cnt=N-1.
  - FULL -> DRAINING on the first accepted column.
  - DRAINING -> EMPTY on the accepted column with col_cnt=N-1.
- Write side:
  - in_ready = (bank[wr_bank] is EMPTY or FILLING). Purely registered state; no combinational path from out_ready.
  - A transfer is in_valid & in_ready. It stores row in_data into bank[wr_bank] row row_cnt, then increments row_cnt.
  - At row_cnt=N-1 the transfer sets the bank FULL, wraps row_cnt to 0 and toggles wr_bank.
- Read side:
  - out_valid = (bank[rd_bank] is FULL or DRAINING).
  - out_data lane r = bank[rd_bank][r][col_cnt], i.e. element M[r][col_cnt]. Registered-state mux only.
  - A transfer is out_valid & out_ready. It increments col_cnt.
  - At col_cnt=N-1 the transfer sets the bank EMPTY, wraps col_cnt to 0 and toggles rd_bank.
  - out_last = out_valid & (col_cnt==N-1).
- Latency: first column of a matrix is valid in the cycle after its last row is accepted (one cycle).
- Throughput: sustained one row in and one column out per cycle, provided neither side stalls.
- Simultaneous read and write in the same cycle always target different banks, or the same bank only in distinct states (never both), so no hazards arise.
- A bank freed on a read transfer is visible to in_ready in the next cycle.
- Stalls:
  - out_ready low holds out_data and out_valid stable.
  - When both banks are FULL or DRAINING, in_ready=0.
- busy = any bank not EMPTY.
- Counter widths: clog2(SYSTOLIC_WIDTH) bits, minimum 1.

Optional Feature:
- Macro TRANSPOSE_BYPASS_EN.
- Defined:
  - Adds input port cfg_bypass (1 bit), sampled when a bank leaves EMPTY and held per bank.
  - For a bypass bank, read beat c outputs stored row c unchanged (lane k = M[c][k]).
  - Handshakes and latency are identical to transpose mode.
  - Changing cfg_bypass mid-matrix has no effect on the bank currently filling.
- Undefined: no cfg_bypass port; always transposes.

Test Plan:
- N=4, W=16. Rows {0x0003,0x0002,0x0001,0x0000}, {0x0013..0x0010}, {0x0023..0x0020}, {0x0033..0x0030}; out_ready=1.
  -> Beat 0 out_data={0x0030,0x0020,0x0010,0x0000}. Beat 3 lanes 0x0033,0x0023,0x0013,0x0003 with out_last=1. out_valid rises one cycle after row 3 is accepted.
- Back-to-back 3 matrices, in_valid and out_ready held high.
  -> in_ready never drops. 12 columns out in 12 consecutive cycles after the initial 4-cycle fill, each correct.
- out_ready=0, push 2 matrices.
  -> in_ready falls after the 8th row and busy=1. Raising out_ready drains 8 columns in order, and in_ready returns the cycle after the 4th column is accepted.
- Random out_ready toggling at 50% across 5 matrices.
  -> out_data is stable while out_valid & !out_ready. All 20 columns match the scoreboard.
- Assert rst_n low after 2 of 4 rows; then push a full matrix.
  -> Immediately in_ready=1, out_valid=0, busy=0. The new matrix outputs correctly with no residue from the partial one.
- TRANSPOSE_BYPASS_EN, cfg_bypass=1 for matrix A and 0 for matrix B.
  -> A is output row-for-row unchanged; B is transposed. clear pulsed mid-B empties the buffer (busy=0 next cycle).
